shift_sequencer: RTL and testbench

//   Multi-cycle shift controller for the ALU shift path. It accepts one shift op (SLL/SRL/SRA) per

---
 rtl/shift_sequencer_if.sv | 26 ++
 rtl/shift_sequencer.sv | 85 ++++++++
 tb/tb_shift_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Request/response handshake bundle for shift_sequencer.
// The slave modport is the sequencer; the master modport is the issuing unit.
interface shift_sequencer_if #(
  parameter int unsigned N = 64
);
  localparam int unsigned AW = $clog2(N);

  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [AW-1:0] in_amt;
  logic [N-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;

  modport master (
    output in_valid, in_op, in_amt, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_op, in_amt, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: consumes the shift amount STEP bits per cycle, then holds the
// result until the consumer takes it.
module shift_sequencer #(
  parameter int unsigned N         = 64,
  parameter int unsigned STEP_LOG2 = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  shift_sequencer_if.slave   bus,
  output logic               busy
);
  localparam int unsigned AW   = $clog2(N);
  localparam int unsigned STEP = 1 << STEP_LOG2;
  localparam logic [AW-1:0] STEP_AMT = AW'(STEP);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    r_state;
  logic [N-1:0]  r_acc;
  logic [AW-1:0] r_rem;
  logic [1:0]    r_op;

  logic          w_accept;
  logic [AW-1:0] w_k;
  logic [AW-1:0] w_rem_next;
  logic [N-1:0]  w_shifted;

  assign w_accept   = bus.in_valid && bus.in_ready;
  assign w_k        = (r_rem < STEP_AMT) ? r_rem : STEP_AMT;
  assign w_rem_next = r_rem - w_k;

  // Arithmetic right shift replicates r_acc[N-1], which no shift step ever changes.
  always_comb begin
    w_shifted = r_acc;
    if (!r_op[0]) begin
      w_shifted = r_acc << w_k;
    end else if (r_op[1]) begin
      w_shifted = $signed(r_acc) >>> w_k;
    end else begin
      w_shifted = r_acc >> w_k;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_rem   <= '0;
      r_op    <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc   <= bus.in_data;
            r_rem   <= bus.in_amt;
            r_op    <= bus.in_op;
            r_state <= (bus.in_amt != '0) ? S_SHIFT : S_DONE;
          end
        end
        S_SHIFT: begin
          r_acc <= w_shifted;
          r_rem <= w_rem_next;
          if (w_rem_next == '0) r_state <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are forced to their reset values while rst_n is low, before any edge.
  assign bus.in_ready  = rst_n && (r_state == S_IDLE);
  assign bus.out_valid = rst_n && (r_state == S_DONE);
  assign bus.out_data  = rst_n ? r_acc : '0;
  assign busy          = rst_n && (r_state != S_IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed vectors plus randomized ops checked
// against a one-shot shift model.
module tb_shift_sequencer;
  localparam int unsigned N         = 64;
  localparam int unsigned STEP_LOG2 = 2;
  localparam int unsigned STEP      = 1 << STEP_LOG2;

  logic clk;
  logic rst_n;
  logic flush;
  logic busy;

  int checks;
  int failures;

  shift_sequencer_if #(.N(N)) bus ();

  shift_sequencer #(
    .N        (N),
    .STEP_LOG2(STEP_LOG2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model_result(input logic [1:0] op, input int amt,
                                               input logic [63:0] data);
    if (!op[0]) return data << amt;
    if (op[1]) return $signed(data) >>> amt;
    return data >> amt;
  endfunction

  function automatic int model_lat(input int amt);
    return 1 + (amt + STEP - 1) / STEP;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for out_valid; lat = -1 on timeout.
  task automatic do_op(input logic [1:0] op, input logic [5:0] amt, input logic [63:0] data,
                       output int lat, output logic [63:0] res);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_amt   = amt;
    bus.in_data  = data;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) lat = -1;
    res = bus.out_data;
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_op     = 2'(($urandom));
    bus.in_amt    = 6'($urandom);
    bus.in_data   = {$urandom, $urandom};
    bus.out_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || busy !== 1'b0 ||
        bus.out_data !== 64'h0) begin
      failures++;
      $display("FAIL reset_hold: rdy=%b vld=%b busy=%b data=%h required 0 0 0 0",
               bus.in_ready, bus.out_valid, busy, bus.out_data);
    end
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 ||
        bus.out_data !== 64'h0) begin
      failures++;
      $display("FAIL reset_idle: rdy=%b vld=%b busy=%b data=%h required 1 0 0 0",
               bus.in_ready, bus.out_valid, busy, bus.out_data);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  ops  [4] = '{2'b00, 2'b11, 2'b01, 2'b01};
    logic [5:0]  amts [4] = '{6'd63, 6'd5, 6'd5, 6'd0};
    logic [63:0] dats [4] = '{64'h1, 64'h8000_0000_0000_00F0, 64'h8000_0000_0000_00F0,
                              64'hDEAD_BEEF};
    logic [63:0] exps [4] = '{64'h8000_0000_0000_0000, 64'hFC00_0000_0000_0007,
                              64'h0400_0000_0000_0007, 64'hDEAD_BEEF};
    int          lats [4] = '{17, 3, 3, 1};
    int          lat;
    logic [63:0] res;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], amts[i], dats[i], lat, res);
      checks++;
      if (res !== exps[i]) begin
        failures++;
        $display("FAIL directed_data[%0d]: got %h required %h", i, res, exps[i]);
      end
      checks++;
      if (lat != lats[i]) begin
        failures++;
        $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, lats[i]);
      end
      release_out();
    end
  endtask

  task automatic test_random();
    int          lat;
    int          amt;
    int          hold;
    logic [1:0]  op;
    logic [63:0] data;
    logic [63:0] res;
    logic [63:0] exp;
    for (int i = 0; i < 40; i++) begin
      op   = 2'($urandom);
      amt  = int'($urandom_range(0, N - 1));
      data = {$urandom, $urandom};
      exp  = model_result(op, amt, data);
      checks++;
      if (bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL random_ready[%0d]: got %b required 1", i, bus.in_ready);
      end
      do_op(op, 6'(amt), data, lat, res);
      checks++;
      if (res !== exp || lat != model_lat(amt)) begin
        failures++;
        $display("FAIL random_op[%0d] op=%b amt=%0d: got %h lat %0d required %h lat %0d",
                 i, op, amt, res, lat, exp, model_lat(amt));
      end
      hold = int'($urandom_range(0, 3));
      for (int c = 0; c < hold; c++) begin
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
          failures++;
          $display("FAIL random_hold[%0d]: vld=%b data=%h required 1 %h",
                   i, bus.out_valid, bus.out_data, exp);
        end
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [63:0] res;
    logic [63:0] data;
    logic [63:0] exp;
    data = {$urandom, $urandom};
    exp  = model_result(2'b01, 9, data);
    do_op(2'b01, 6'd9, data, lat, res);
    // A request offered while DONE must be ignored.
    bus.in_valid = 1'b1;
    bus.in_amt   = 6'd1;
    bus.in_data  = ~data;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure[%0d]: vld=%b data=%h rdy=%b required 1 %h 0",
                 c, bus.out_valid, bus.out_data, bus.in_ready, exp);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    release_out();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release: vld=%b rdy=%b busy=%b required 0 1 0",
               bus.out_valid, bus.in_ready, busy);
    end
    data = {$urandom, $urandom};
    do_op(2'b00, 6'd6, data, lat, res);
    checks++;
    if (res !== (data << 6) || lat != 3) begin
      failures++;
      $display("FAIL backpressure_next: got %h lat %0d required %h lat 3", res, lat, data << 6);
    end
    release_out();
  endtask

  task automatic test_flush();
    int          lat;
    bit          seen;
    logic [63:0] res;
    logic [63:0] data;
    bus.in_valid = 1'b1;
    bus.in_op    = 2'b00;
    bus.in_amt   = 6'd40;
    bus.in_data  = {$urandom, $urandom};
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_shift: busy=%b rdy=%b vld=%b required 0 1 0",
               busy, bus.in_ready, bus.out_valid);
    end
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_valid: got out_valid=1 after flush required 0");
    end
    bus.in_valid = 1'b1;
    bus.in_amt   = 6'd3;
    flush        = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_blocks_accept: busy=%b required 0", busy);
    end
    data = {$urandom, $urandom};
    do_op(2'b10, 6'd0, data, lat, res);
    bus.out_ready = 1'b1;
    flush         = 1'b1;
    tick();
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_data !== data) begin
      failures++;
      $display("FAIL flush_done: vld=%b busy=%b data=%h required 0 0 %h",
               bus.out_valid, busy, bus.out_data, data);
    end
  endtask

  task automatic test_reset_mid();
    bus.in_valid = 1'b1;
    bus.in_op    = 2'b11;
    bus.in_amt   = 6'd50;
    bus.in_data  = {$urandom | 32'h8000_0000, $urandom};
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || busy !== 1'b0 ||
        bus.out_data !== 64'h0) begin
      failures++;
      $display("FAIL reset_mid: rdy=%b vld=%b busy=%b data=%h required 0 0 0 0",
               bus.in_ready, bus.out_valid, busy, bus.out_data);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.out_data !== 64'h0) begin
      failures++;
      $display("FAIL reset_mid_idle: rdy=%b busy=%b data=%h required 1 0 0",
               bus.in_ready, busy, bus.out_data);
    end
  endtask

  task automatic test_input_change();
    int          lat;
    logic [63:0] data;
    logic [63:0] exp;
    data = {$urandom, $urandom};
    exp  = model_result(2'b11, 22, data);
    bus.in_valid = 1'b1;
    bus.in_op    = 2'b11;
    bus.in_amt   = 6'd22;
    bus.in_data  = data;
    tick();
    bus.in_valid = 1'b0;
    bus.in_op    = 2'b00;
    bus.in_amt   = 6'd1;
    bus.in_data  = ~data;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    checks++;
    if (bus.out_data !== exp || lat != model_lat(22)) begin
      failures++;
      $display("FAIL input_change: got %h lat %0d required %h lat %0d",
               bus.out_data, lat, exp, model_lat(22));
    end
    release_out();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_input_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
